// File: rtl/pwm_cfg_dispatcher.sv
// pwm_cfg_dispatcher: parses 14-byte UART config packets and hands PWM channel
// settings out over a valid/ready port, replying ACK/NAK over a second one.
`timescale 1ns/1ps
module pwm_cfg_dispatcher #(
  parameter int CH_NUM      = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [CH_NUM-1:0] cfg_sel,
  output logic              cfg_ctrl_sta,
  output logic [7:0]        cfg_duty,
  output logic [15:0]       cfg_dessert,
  output logic [7:0]        cfg_pulse_num,
  output logic [31:0]       cfg_pat,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic              resp_valid,
  output logic [7:0]        resp_data,
  input  logic              resp_ready,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_err_cnt,
  output logic [2:0]        err_code
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CH_MAX = 8'(CH_NUM);
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CRC, S_TAIL, S_DISPATCH, S_RESP} state_t;
  state_t r_state, w_next;
  logic [87:0] r_pay;
  logic [3:0] r_idx;
  logic [7:0] r_sum, r_crc, r_duty, r_pn, r_resp;
  logic [15:0] r_des, r_ok, r_err;
  logic [31:0] r_pat;
  logic [2:0] r_code, w_err;
  logic r_ctrl;
  logic [TW-1:0] r_idle;
  logic [7:0] w_func, w_ch, w_chm1;
  logic w_rxst, w_to, w_tail, w_nak, w_ack;
  assign w_func = r_pay[87:80];
  assign w_ch = r_pay[79:72];
  assign w_chm1 = w_ch - 8'd1;
  assign w_rxst = r_state == S_PAYLOAD || r_state == S_CRC || r_state == S_TAIL;
  assign w_to = w_rxst && !rx_valid && r_idle == TW'(TIMEOUT_CYC - 1);
  assign w_tail = r_state == S_TAIL && rx_valid;
  // first failing check wins: tail, crc, func, channel
  assign w_err = rx_data != 8'hAA ? 3'd1 :
                 r_crc != r_sum ? 3'd2 :
                 (w_func != 8'h01 && w_func != 8'h02) ? 3'd3 :
                 (w_ch == 8'd0 || w_ch > CH_MAX) ? 3'd4 : 3'd0;
  assign w_nak = (w_tail && w_err != 3'd0) || w_to;
  assign w_ack = r_state == S_DISPATCH && cfg_ready;
  assign cfg_valid = r_state == S_DISPATCH;
  assign cfg_sel = cfg_valid ? CH_NUM'(1) << w_chm1 : '0;
  assign resp_valid = r_state == S_RESP;
  assign cfg_ctrl_sta = r_ctrl;
  assign cfg_duty = r_duty;
  assign cfg_dessert = r_des;
  assign cfg_pulse_num = r_pn;
  assign cfg_pat = r_pat;
  assign resp_data = r_resp;
  assign pkt_ok_cnt = r_ok;
  assign pkt_err_cnt = r_err;
  assign err_code = r_code;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (rx_valid && rx_data == 8'h55) w_next = S_PAYLOAD;
      S_PAYLOAD:  if (rx_valid && r_idx == 4'd10) w_next = S_CRC;
      S_CRC:      if (rx_valid) w_next = S_TAIL;
      S_TAIL:     if (rx_valid) w_next = w_err == 3'd0 ? S_DISPATCH : S_RESP;
      S_DISPATCH: if (cfg_ready) w_next = S_RESP;
      S_RESP:     if (resp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_to) w_next = S_RESP;
  end
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      r_pay <= '0;
      r_idx <= '0;
      r_sum <= '0;
      r_crc <= '0;
      r_idle <= '0;
      r_ctrl <= 1'b0;
      r_duty <= '0;
      r_des <= '0;
      r_pn <= '0;
      r_pat <= '0;
      r_resp <= '0;
      r_ok <= '0;
      r_err <= '0;
      r_code <= '0;
    end else begin
      r_idle <= (rx_valid || !w_rxst) ? '0 : r_idle + 1'b1;
      if (r_state == S_IDLE && rx_valid && rx_data == 8'h55) begin
        r_idx <= '0;
        r_sum <= '0;
      end
      if (r_state == S_PAYLOAD && rx_valid) begin
        r_pay <= {r_pay[79:0], rx_data};
        r_idx <= r_idx + 4'd1;
        r_sum <= r_sum + rx_data;
      end
      if (r_state == S_CRC && rx_valid) r_crc <= rx_data;
      if (w_tail && w_err == 3'd0) begin
        r_ctrl <= w_func == 8'h02 ? 1'b0 : |r_pay[71:64];
        r_duty <= r_pay[63:56];
        r_des <= r_pay[55:40];
        r_pn <= r_pay[39:32];
        r_pat <= r_pay[31:0];
      end
      if (w_nak) begin
        r_code <= w_to ? 3'd5 : w_err;
        r_resp <= 8'h15;
      end
      if (w_ack) r_resp <= 8'h06;
      r_err <= r_err + {15'd0, w_nak && r_err != 16'hFFFF};
      r_ok <= r_ok + {15'd0, w_ack && r_ok != 16'hFFFF};
    end
endmodule
